// File: rtl/dp_ram_arbiter_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
//   req_idx_t  : requester index
//   port_cmd_t : one RAM port command {en, we, addr, wdata}
//   rr_next    : modular add of two indices (wraps at ARB_NUM_REQ)
package dp_ram_arb_pkg;

  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_DEPTH      = 256;
  localparam int ARB_ADDR_WIDTH = $clog2(ARB_DEPTH);
  localparam int ARB_IDX_WIDTH  = $clog2(ARB_NUM_REQ);

  typedef logic [ARB_IDX_WIDTH-1:0] req_idx_t;

  typedef struct packed {
    logic                      en;
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } port_cmd_t;

  // (ptr + idx) mod ARB_NUM_REQ; also works when ARB_NUM_REQ is not a power of two
  function automatic req_idx_t rr_next(req_idx_t ptr, req_idx_t idx);
    int sum;
    sum = int'(ptr) + int'(idx);
    if (sum >= ARB_NUM_REQ) sum -= ARB_NUM_REQ;
    return req_idx_t'(sum);
  endfunction

endpackage

// File: rtl/dp_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
//   master : requesters (drive req_*, receive req_ready and resp_*)
//   slave  : arbiter
interface dp_ram_arbiter_if
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dp_ram_arbiter_rr_pick.sv
// Rotating-priority finder: first set bit of req at or after start (wrapping).
//   req   : candidate mask
//   start : index with highest priority
//   found : any bit set
//   idx   : winning index (0 when nothing found)
module rr_pick
  import dp_ram_arb_pkg::*;
#(
  parameter int N = ARB_NUM_REQ
) (
  input  logic [N-1:0] req,
  input  req_idx_t     start,
  output logic         found,
  output req_idx_t     idx
);

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[rr_next(start, req_idx_t'(i))]) begin
        found = 1'b1;
        idx   = rr_next(start, req_idx_t'(i));
      end
    end
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares one dual-port RAM among NUM_REQ requesters. Up to two requests are
// granted per cycle (first winner -> port A, second -> port B) and read data
// is routed back to its owner one cycle later.
//   clk, reset         : clock, async active-low reset
//   bus                : requester handshake / response bus (slave side)
//   ram_*_a / ram_*_b  : RAM port commands and registered read returns
//   protocol_err       : sticky, RAM read-valid disagreed with an issued read
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int DEPTH      = ARB_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  dp_ram_arbiter_if.slave       bus,
  output logic                  ram_enable_a,
  output logic                  ram_enable_b,
  output logic                  ram_write_enable_a,
  output logic                  ram_write_enable_b,
  output logic [ADDR_WIDTH-1:0] ram_address_a,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  output logic [DATA_WIDTH-1:0] ram_write_data_a,
  output logic [DATA_WIDTH-1:0] ram_write_data_b,
  input  logic                  ram_read_valid_a,
  input  logic                  ram_read_valid_b,
  input  logic [DATA_WIDTH-1:0] ram_read_data_a,
  input  logic [DATA_WIDTH-1:0] ram_read_data_b,
  output logic                  protocol_err
);

  logic [IDX_WIDTH-1:0]  rr_ptr;
  logic [IDX_WIDTH-1:0]  g0, g1;
  logic                  found0, found1;
  logic [NUM_REQ-1:0]    mask1;
  logic [ADDR_WIDTH-1:0] g0_addr;
  logic [IDX_WIDTH-1:0]  tag_a_q, tag_b_q;
  logic                  tag_a_vld_q, tag_b_vld_q;
  port_cmd_t             cmd_a, cmd_b;

  rr_pick #(.N(NUM_REQ)) u_pick0 (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .found (found0),
    .idx   (g0)
  );

  assign g0_addr = bus.req_addr[g0*ADDR_WIDTH +: ADDR_WIDTH];

  // Second winner: exclude g0 and anything that would collide with it.
  // Two reads of the same word are harmless and stay eligible.
  always_comb begin
    mask1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask1[i] = found0 && bus.req_valid[i] && (req_idx_t'(i) != g0) &&
                 !((bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == g0_addr) &&
                   (bus.req_we[g0] || bus.req_we[i]));
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick1 (
    .req   (mask1),
    .start (rr_next(g0, req_idx_t'(1))),
    .found (found1),
    .idx   (g1)
  );

  // Grants and port commands are held at zero while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    cmd_a         = '0;
    cmd_b         = '0;
    if (reset) begin
      if (found0) begin
        bus.req_ready[g0] = 1'b1;
        cmd_a.en          = 1'b1;
        cmd_a.we          = bus.req_we[g0];
        cmd_a.addr        = g0_addr;
        cmd_a.wdata       = bus.req_wdata[g0*DATA_WIDTH +: DATA_WIDTH];
      end
      if (found1) begin
        bus.req_ready[g1] = 1'b1;
        cmd_b.en          = 1'b1;
        cmd_b.we          = bus.req_we[g1];
        cmd_b.addr        = bus.req_addr[g1*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_b.wdata       = bus.req_wdata[g1*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ram_enable_a       = cmd_a.en;
  assign ram_write_enable_a = cmd_a.we;
  assign ram_address_a      = cmd_a.addr;
  assign ram_write_data_a   = cmd_a.wdata;
  assign ram_enable_b       = cmd_b.en;
  assign ram_write_enable_b = cmd_b.we;
  assign ram_address_b      = cmd_b.addr;
  assign ram_write_data_b   = cmd_b.wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      tag_a_vld_q  <= 1'b0;
      tag_b_vld_q  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (found1)      rr_ptr <= rr_next(g1, req_idx_t'(1));
      else if (found0) rr_ptr <= rr_next(g0, req_idx_t'(1));
      tag_a_q      <= g0;
      tag_b_q      <= g1;
      tag_a_vld_q  <= found0 && !bus.req_we[g0];
      tag_b_vld_q  <= found1 && !bus.req_we[g1];
      protocol_err <= protocol_err ||
                      (tag_a_vld_q != ram_read_valid_a) ||
                      (tag_b_vld_q != ram_read_valid_b);
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    if (reset && tag_a_vld_q && ram_read_valid_a) begin
      bus.resp_valid[tag_a_q]                       = 1'b1;
      bus.resp_data[tag_a_q*DATA_WIDTH +: DATA_WIDTH] = ram_read_data_a;
    end
    if (reset && tag_b_vld_q && ram_read_valid_b) begin
      bus.resp_valid[tag_b_q]                       = 1'b1;
      bus.resp_data[tag_b_q*DATA_WIDTH +: DATA_WIDTH] = ram_read_data_b;
    end
  end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: behavioural RAM, scan-based arbitration model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dp_ram_arbiter;
  import dp_ram_arb_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dp_ram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          en_a, en_b, we_a, we_b, rv_a, rv_b, perr;
  logic [AW-1:0] ad_a, ad_b;
  logic [DW-1:0] wd_a, wd_b, rd_a, rd_b;

  dp_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .ram_enable_a       (en_a),
    .ram_enable_b       (en_b),
    .ram_write_enable_a (we_a),
    .ram_write_enable_b (we_b),
    .ram_address_a      (ad_a),
    .ram_address_b      (ad_b),
    .ram_write_data_a   (wd_a),
    .ram_write_data_b   (wd_b),
    .ram_read_valid_a   (rv_a),
    .ram_read_valid_b   (rv_b),
    .ram_read_data_a    (rd_a),
    .ram_read_data_b    (rd_b),
    .protocol_err       (perr)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return 32'hC0DE0000 ^ 32'(i * 32'h00010003);
  endfunction

  // ---------------- behavioural RAM (port A wins on write) ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  logic ram_init = 1'b0;
  logic rv_a_q = 1'b0, rv_b_q = 1'b0;
  logic force_rv_a = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end
    rv_a_q <= en_a && !we_a;
    rv_b_q <= en_b && !we_b;
    if (en_a && !we_a) rd_a <= ram_mem[ad_a];
    if (en_b && !we_b) rd_b <= ram_mem[ad_b];
    if (en_b && we_b) ram_mem[ad_b] <= wd_b;
    if (en_a && we_a) ram_mem[ad_a] <= wd_a;
  end
  assign rv_a = rv_a_q | force_rv_a;
  assign rv_b = rv_b_q;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mmem [DEPTH];
  int  m_ptr = 0;
  bit  pa_v = 0, pb_v = 0;
  int  pa_i = 0, pb_i = 0;
  logic [DW-1:0] pa_d = '0, pb_d = '0;
  bit  m_perr = 0;

  initial for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);

  function automatic logic [AW-1:0] raddr(int i);
    return bus.req_addr[i*AW +: AW];
  endfunction

  function automatic bit collide(int j, int g);
    return (raddr(j) == raddr(g)) && (bus.req_we[j] || bus.req_we[g]);
  endfunction

  int g0, g1;
  logic [NR-1:0]    e_rdy, e_rv;
  logic [NR*DW-1:0] e_rd;

  always @(negedge clk) begin : compare_p
    if (!reset) begin
      check("rst_ready", 256'(bus.req_ready), 256'(0));
      check("rst_ports", 256'({en_a, en_b, we_a, we_b, ad_a, ad_b, wd_a, wd_b}), 256'(0));
      check("rst_resp_valid", 256'(bus.resp_valid), 256'(0));
      check("rst_resp_data", 256'(bus.resp_data), 256'(0));
      check("rst_perr", 256'(perr), 256'(0));
      m_ptr = 0; pa_v = 0; pb_v = 0; m_perr = 0;
    end else begin
      g0 = -1; g1 = -1;
      for (int k = 0; k < NR; k++) begin
        if (bus.req_valid[(m_ptr + k) % NR]) begin
          if (g0 < 0) g0 = (m_ptr + k) % NR;
          else if (g1 < 0 && !collide((m_ptr + k) % NR, g0)) g1 = (m_ptr + k) % NR;
        end
      end
      e_rdy = '0;
      if (g0 >= 0) e_rdy[g0] = 1'b1;
      if (g1 >= 0) e_rdy[g1] = 1'b1;
      check("ready", 256'(bus.req_ready), 256'(e_rdy));
      if (g0 >= 0)
        check("port_a", 256'({en_a, we_a, ad_a, wd_a}),
              256'({1'b1, bus.req_we[g0], raddr(g0), bus.req_wdata[g0*DW +: DW]}));
      else
        check("port_a_idle", 256'({en_a, we_a, ad_a, wd_a}), 256'(0));
      if (g1 >= 0)
        check("port_b", 256'({en_b, we_b, ad_b, wd_b}),
              256'({1'b1, bus.req_we[g1], raddr(g1), bus.req_wdata[g1*DW +: DW]}));
      else
        check("port_b_idle", 256'({en_b, we_b, ad_b, wd_b}), 256'(0));

      e_rv = '0; e_rd = '0;
      if (pa_v && rv_a) begin e_rv[pa_i] = 1'b1; e_rd[pa_i*DW +: DW] = pa_d; end
      if (pb_v && rv_b) begin e_rv[pb_i] = 1'b1; e_rd[pb_i*DW +: DW] = pb_d; end
      check("resp_valid", 256'(bus.resp_valid), 256'(e_rv));
      check("resp_data", 256'(bus.resp_data), 256'(e_rd));
      check("perr", 256'(perr), 256'(m_perr));

      // effect of the coming clock edge
      m_perr = m_perr || (pa_v != rv_a) || (pb_v != rv_b);
      pa_v = (g0 >= 0) && !bus.req_we[g0];
      pb_v = (g1 >= 0) && !bus.req_we[g1];
      if (pa_v) begin pa_i = g0; pa_d = mmem[raddr(g0)]; end
      if (pb_v) begin pb_i = g1; pb_d = mmem[raddr(g1)]; end
      if (g1 >= 0 && bus.req_we[g1]) mmem[raddr(g1)] = bus.req_wdata[g1*DW +: DW];
      if (g0 >= 0 && bus.req_we[g0]) mmem[raddr(g0)] = bus.req_wdata[g0*DW +: DW];
      if (g1 >= 0)      m_ptr = (g1 + 1) % NR;
      else if (g0 >= 0) m_ptr = (g0 + 1) % NR;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(int i, bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_we[i]            = w;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_rst_ready", 256'(bus.req_ready), 256'(0));
    check("lit_rst_en", 256'({en_a, en_b}), 256'(0));
    tick();
    reset = 1'b1;

    // single requester write then read
    set_req(1, 1, 1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("lit_wr_ready", 256'(bus.req_ready), 256'(4'b0010));
    check("lit_wr_port_a", 256'({en_a, we_a, ad_a, wd_a}), 256'({1'b1, 1'b1, 8'h10, 32'hDEADBEEF}));
    check("lit_wr_port_b", 256'(en_b), 256'(0));
    tick();
    set_req(1, 1, 0, 8'h10, '0);
    @(negedge clk);
    check("lit_rd_ready", 256'(bus.req_ready), 256'(4'b0010));
    check("lit_rd_port", 256'({en_a, we_a, en_b}), 256'(3'b100));
    tick();
    drive_idle();
    @(negedge clk);
    check("lit_rd_resp_valid", 256'(bus.resp_valid), 256'(4'b0010));
    check("lit_rd_resp_data", 256'(bus.resp_data[63:32]), 256'(32'hDEADBEEF));
    tick();

    // four readers, pointer starting at 0
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1, 0, 8'(8'h40 + i), '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("lit_rr_ready", 256'(bus.req_ready), 256'((c % 2 == 0) ? 4'b0011 : 4'b1100));
      if (c > 0) begin
        check("lit_rr_resp_valid", 256'(bus.resp_valid), 256'((c % 2 == 1) ? 4'b0011 : 4'b1100));
        for (int i = 0; i < NR; i++)
          if (((c % 2 == 1) && i < 2) || ((c % 2 == 0) && i >= 2))
            check("lit_rr_data", 256'(bus.resp_data[i*DW +: DW]), 256'(init_word(8'h40 + i)));
      end
      tick();
    end
    drive_idle();
    @(negedge clk);
    check("lit_rr_last_resp", 256'(bus.resp_valid), 256'(4'b1100));
    tick();

    // write/read collision at 0x20
    set_req(0, 1, 1, 8'h20, 32'h12345678);
    set_req(1, 1, 0, 8'h20, '0);
    @(negedge clk);
    check("lit_col_ready0", 256'(bus.req_ready), 256'(4'b0001));
    check("lit_col_port_b", 256'(en_b), 256'(0));
    tick();
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    check("lit_col_ready1", 256'(bus.req_ready), 256'(4'b0010));
    tick();
    drive_idle();
    @(negedge clk);
    check("lit_col_resp", 256'({bus.resp_valid, bus.resp_data[63:32]}), 256'({4'b0010, 32'h12345678}));
    tick();

    // two reads of one address share the cycle
    set_req(2, 1, 0, 8'h05, '0);
    set_req(3, 1, 0, 8'h05, '0);
    @(negedge clk);
    check("lit_rr2_ready", 256'(bus.req_ready), 256'(4'b1100));
    check("lit_rr2_ports", 256'({en_a, ad_a, en_b, ad_b}), 256'({1'b1, 8'h05, 1'b1, 8'h05}));
    tick();
    drive_idle();
    @(negedge clk);
    check("lit_rr2_resp_valid", 256'(bus.resp_valid), 256'(4'b1100));
    check("lit_rr2_data", 256'({bus.resp_data[95:64], bus.resp_data[127:96]}),
          256'({init_word(5), init_word(5)}));
    tick();

    // reset with a read in flight
    set_req(1, 1, 0, 8'h07, '0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("lit_rst_inflight_resp", 256'(bus.resp_valid), 256'(0));
    check("lit_rst_inflight_en", 256'({en_a, en_b, bus.req_ready}), 256'(0));
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1, 0, 8'(8'h60 + i), '0);
    @(negedge clk);
    check("lit_post_rst_ready", 256'(bus.req_ready), 256'(4'b0011));
    tick();
    drive_idle();
    tick();

    // spurious read-valid
    force_rv_a = 1'b1;
    @(negedge clk);
    check("lit_perr_pre", 256'(perr), 256'(0));
    tick();
    force_rv_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lit_perr_sticky", 256'(perr), 256'(1));
      tick();
    end
    do_reset();
    @(negedge clk);
    check("lit_perr_cleared", 256'(perr), 256'(0));
    tick();

    // random traffic over a small address window to provoke collisions
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NR; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 7)), $urandom);
      tick();
    end
    drive_idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
